// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep sequencer.
// The triangle sweep is enabled by defining DDS_SWEEP_TRIANGLE_EN.
package dds_pkg;

    localparam int DDS_KW = 32;
    localparam int DDS_PW = 11;
    localparam int DDS_CW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_UP = 2'd1,
        RUN_DN = 2'd2,
        FIN    = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that flags when the current dwell has run out.
// Holds at zero once expired until it is reloaded.
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int CW = DDS_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          expire
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Stepped linear frequency sweep sequencer driving the DDS K/P inputs.
// Define DDS_SWEEP_TRIANGLE_EN to sweep back down after the top point.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int KW = DDS_KW,
    parameter int PW = DDS_PW,
    parameter int CW = DDS_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] k_start,
    input  logic [KW-1:0] k_step,
    input  logic [CW-1:0] step_count,
    input  logic [CW-1:0] dwell,
    input  logic [PW-1:0] phase_off,
    output logic [KW-1:0] K,
    output logic [PW-1:0] P,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] point_idx
);

    sweep_state_t state, state_nxt;

    logic [KW-1:0] step_r;
    logic [CW-1:0] n_r;
    logic [CW-1:0] dwell_r;

    logic go;
    logic adv;
    logic ret;
    logic expire;

    dds_dwell_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (go | adv | ret),
        .value  (go ? dwell : dwell_r),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        adv       = 1'b0;
        ret       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = RUN_UP;
                    go        = 1'b1;
                end
            end
            RUN_UP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (expire) begin
                    if (point_idx != n_r) begin
                        adv = 1'b1;
                    end else begin
`ifdef DDS_SWEEP_TRIANGLE_EN
                        if (n_r != '0) begin
                            state_nxt = RUN_DN;
                            ret       = 1'b1;
                        end else begin
                            state_nxt = FIN;
                        end
`else
                        state_nxt = FIN;
`endif
                    end
                end
            end
            RUN_DN: begin
`ifdef DDS_SWEEP_TRIANGLE_EN
                if (abort) begin
                    state_nxt = IDLE;
                end else if (expire) begin
                    if (point_idx != '0) begin
                        ret = 1'b1;
                    end else begin
                        state_nxt = FIN;
                    end
                end
`else
                state_nxt = IDLE;
`endif
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Config is captured at start so input changes mid-sweep are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            K         <= '0;
            P         <= '0;
            point_idx <= '0;
            step_r    <= '0;
            n_r       <= '0;
            dwell_r   <= '0;
        end else if (go) begin
            K         <= k_start;
            P         <= phase_off;
            point_idx <= '0;
            step_r    <= k_step;
            n_r       <= step_count;
            dwell_r   <= dwell;
        end else if (adv) begin
            K         <= K + step_r;
            point_idx <= point_idx + 1'b1;
        end else if (ret) begin
            K         <= K - step_r;
            point_idx <= point_idx - 1'b1;
        end
    end

    assign busy = (state == RUN_UP) || (state == RUN_DN);
    assign done = (state == FIN);

endmodule
